// File: rtl/psum_accumulator.sv
// psum_accumulator: sums a window of cfg_len+1 signed products into one ACC_W-bit partial sum.
// Optional macro PSUM_SAT_EN: saturate each add instead of wrapping modulo 2^ACC_W.
module psum_accumulator #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int unsigned NumGroups = ACC_W / 4;
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [LEN_W:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] in_ext, sum, add_res;
  logic             add_ovf, accept;

  assign in_ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};

  // Ripple of 4-bit carry-lookahead groups; each group exposes its carry-out as co.
  for (genvar gi = 0; gi < NumGroups; gi++) begin : g_cla
    logic [3:0] g, p, c;
    logic       cin, co;
    if (gi == 0) begin : g_first
      assign cin = 1'b0;
    end else begin : g_chain
      assign cin = g_cla[gi-1].co;
    end
    assign g    = acc_q[4*gi +: 4] & in_ext[4*gi +: 4];
    assign p    = acc_q[4*gi +: 4] ^ in_ext[4*gi +: 4];
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                  (&p & cin);
    assign sum[4*gi +: 4] = p ^ c;
  end

  assign add_ovf = (acc_q[ACC_W-1] == in_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

`ifdef PSUM_SAT_EN
  // Clamp toward the sign both operands share.
  assign add_res = add_ovf ? (acc_q[ACC_W-1] ? AccMin : AccMax) : sum;
`else
  assign add_res = sum;
`endif

  assign in_ready  = reset_n && (state_q != StHold);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StHold);
  assign out_data  = out_valid ? acc_q : '0;
  assign out_ovf   = out_valid && ovf_q;
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          acc_d   = in_ext;
          len_d   = cfg_len;
          cnt_d   = (LEN_W+1)'(1);
          ovf_d   = 1'b0;
          state_d = (cfg_len == '0) ? StHold : StAcc;
        end
      end
      StAcc: begin
        if (accept) begin
          acc_d = add_res;
          ovf_d = ovf_q | add_ovf;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == {1'b0, len_q}) state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
